// File: rtl/dcache_refill_pkg.sv
// Shared types and constants for the d-cache refill controller.
package dcache_refill_pkg;

  localparam int          WORD_BYTES = 4;
  localparam logic [31:0] EMPTY_BASE = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    INVAL,
    FILL,
    BOUND,
    BASE,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/dcache_refill_ctrl_if.sv
// Backing-memory read bus between the refill controller and memory.
interface dcache_refill_ctrl_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);

endinterface

// File: rtl/dcache_refill_ctrl_wdog.sv
// Per-word memory wait watchdog: reloaded at each new word, expires after
// MEM_TIMEOUT request cycles without an ack.
module refill_wdog #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic ack,
  output logic expired
);

  localparam int            TW   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] LOAD = TW'(MEM_TIMEOUT - 1);

  logic [TW-1:0] count;
  logic          armed;

  // count holds the request cycles left after the current one
  assign expired = armed && (count == '0) && !ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      armed <= 1'b0;
    end else if (start) begin
      count <= LOAD;
      armed <= 1'b1;
    end else if (ack || expired) begin
      armed <= 1'b0;
    end else if (armed) begin
      count <= count - TW'(1);
    end
  end

endmodule

// File: rtl/dcache_refill_ctrl.sv
// D-cache refill sequencer: empties the window, fills LINE_WORDS words from
// memory, then writes bound and base so the window becomes valid last.
module dcache_refill_ctrl
  import dcache_refill_pkg::*;
#(
  parameter int LINE_WORDS  = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_in,
  input  logic [31:0] miss_addr,
  output logic        stall_out,
  output logic        cache_override,
  output logic [31:0] cache_addr,
  output logic [31:0] cache_wdata,
  output logic [3:0]  cache_wstrb,
  output logic        base_we,
  output logic [31:0] base_data,
  output logic        bound_we,
  output logic [31:0] bound_data,
  dcache_refill_ctrl_if.master mem,
  output logic        err_out,
  input  logic        err_clr
);

  // state | meaning
  // IDLE  | waiting for a miss; stall follows miss_in
  // INVAL | base <= EMPTY_BASE so the window matches nothing during the fill
  // FILL  | one memory read per word, each ack written straight into the cache
  // BOUND | bound <= last byte of the window
  // BASE  | base <= window start; window valid from here on
  // DONE  | one cycle with stall released, miss_in ignored
  // ERROR | memory timeout; stall held until err_clr

  localparam int          CW         = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int          LINE_BYTES = LINE_WORDS * WORD_BYTES;
  localparam logic [31:0] LINE_LAST  = 32'(LINE_BYTES - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(LINE_WORDS - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [31:0]   win_base;
  logic [31:0]   next_ofs;
  logic          mem_req_q;
  logic [31:0]   mem_addr_q;
  logic          word_ack;
  logic          last_word;
  logic          wdog_start;
  logic          wdog_expired;

  assign cnt_next   = cnt + CW'(1);
  assign next_ofs   = 32'({cnt_next, 2'b00});
  assign word_ack   = mem_req_q && mem.mem_ack;
  assign last_word  = (cnt == LAST_CNT);
  assign wdog_start = (state == INVAL) || (word_ack && !last_word);

  refill_wdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (wdog_start),
    .ack     (word_ack),
    .expired (wdog_expired)
  );

  // Fill writes follow the ack combinationally so zero-wait memory gives one word per cycle
  assign cache_override = word_ack;
  assign cache_addr     = word_ack ? mem_addr_q    : 32'h0;
  assign cache_wdata    = word_ack ? mem.mem_rdata : 32'h0;
  assign cache_wstrb    = word_ack ? 4'b1111       : 4'b0000;
  assign stall_out      = (state == IDLE) ? miss_in : (state != DONE);
  assign mem.mem_req    = mem_req_q;
  assign mem.mem_addr   = mem_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      win_base   <= 32'h0;
      err_out    <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0;
      base_we    <= 1'b0;
      base_data  <= 32'h0;
      bound_we   <= 1'b0;
      bound_data <= 32'h0;
    end else begin
      base_we    <= 1'b0;
      base_data  <= 32'h0;
      bound_we   <= 1'b0;
      bound_data <= 32'h0;
      case (state)
        IDLE: begin
          if (miss_in) begin
            win_base  <= miss_addr & ~LINE_LAST;
            cnt       <= '0;
            base_we   <= 1'b1;
            base_data <= EMPTY_BASE;
            state     <= INVAL;
          end
        end
        INVAL: begin
          mem_req_q  <= 1'b1;
          mem_addr_q <= win_base;
          state      <= FILL;
        end
        FILL: begin
          if (word_ack) begin
            cnt <= cnt_next;
            if (last_word) begin
              mem_req_q  <= 1'b0;
              mem_addr_q <= 32'h0;
              bound_we   <= 1'b1;
              bound_data <= win_base + LINE_LAST;
              state      <= BOUND;
            end else begin
              mem_addr_q <= win_base + next_ofs;
            end
          end else if (wdog_expired) begin
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'h0;
            err_out    <= 1'b1;
            state      <= ERROR;
          end
        end
        BOUND: begin
          base_we   <= 1'b1;
          base_data <= win_base;
          state     <= BASE;
        end
        BASE:  state <= DONE;
        DONE:  state <= IDLE;
        ERROR: begin
          if (err_clr) begin
            err_out <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
